// File: rtl/timer_pkg.sv
// Shared types and default constants for the expiry timer.
package timer_pkg;

  localparam int DEF_CNT_W    = 11;
  localparam int DEF_LOAD_VAL = 1800;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/timer_down_counter.sv
// Loadable down-counter with hold, saturating at zero, plus a lookahead
// flag that is high when the next decrement will reach zero.
module timer_down_counter #(
  parameter int CNT_W    = 11,
  parameter int LOAD_VAL = 1800
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             is_one
);

  localparam logic [CNT_W-1:0] LOAD_VEC = CNT_W'(LOAD_VAL);
  localparam logic [CNT_W-1:0] ONE_VEC  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_VEC = '0;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load wins over decrement; decrement never goes below zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VEC;
    end else if (dec && (count_q != ZERO_VEC)) begin
      count_d = count_q - ONE_VEC;
    end
  end

  // Counter register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= ZERO_VEC;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign is_one = (count_q == ONE_VEC);

endmodule

// File: rtl/timer_fsm.sv
// One-shot expiry timer: ct (re)starts a LOAD_VAL-edge countdown, t is a
// level that stays high from expiry until the next ct or reset.
module timer_fsm
  import timer_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOAD_VAL = DEF_LOAD_VAL
) (
  input  logic             tclk,
  input  logic             rst_n,
  input  logic             ct,
  output logic             t,
  output logic [CNT_W-1:0] count
);

  state_e state_q;
  state_e state_d;
  logic   load;
  logic   dec;
  logic   is_one;

  timer_down_counter #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (LOAD_VAL)
  ) u_cnt (
    .clk    (tclk),
    .rst_n  (rst_n),
    .load   (load),
    .dec    (dec),
    .count  (count),
    .is_one (is_one)
  );

  // Next-state and datapath controls; a sampled ct restarts from any state.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    dec     = 1'b0;
    if (ct) begin
      load    = 1'b1;
      state_d = COUNT;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        COUNT: begin
          dec = 1'b1;
          if (is_one) state_d = DONE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge tclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Terminal flag is decoded purely from the registered state.
  assign t = (state_q == DONE);

endmodule

// File: tb/tb_timer_fsm.sv
// Directed bench for timer_fsm: three instances (LOAD_VAL 1800, 1, 2047)
// share stimulus and are compared every cycle against a counting model.
module tb_timer_fsm;

  localparam int CW = 11;
  localparam int L0 = 1800;
  localparam int L1 = 1;
  localparam int L2 = 2047;

  logic          tclk = 1'b0;
  logic          rst_n;
  logic          ct;
  logic          t_o   [3];
  logic [CW-1:0] cnt_o [3];

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  // Model: remaining edges to expiry and whether a run was ever started.
  int m_cnt [3] = '{0, 0, 0};
  bit m_arm [3] = '{0, 0, 0};

  always #5 tclk = ~tclk;

  timer_fsm #(.CNT_W(CW), .LOAD_VAL(L0)) dut0 (
    .tclk(tclk), .rst_n(rst_n), .ct(ct), .t(t_o[0]), .count(cnt_o[0]));
  timer_fsm #(.CNT_W(CW), .LOAD_VAL(L1)) dut1 (
    .tclk(tclk), .rst_n(rst_n), .ct(ct), .t(t_o[1]), .count(cnt_o[1]));
  timer_fsm #(.CNT_W(CW), .LOAD_VAL(L2)) dut2 (
    .tclk(tclk), .rst_n(rst_n), .ct(ct), .t(t_o[2]), .count(cnt_o[2]));

  function automatic int load_of(input int i);
    case (i)
      0:       return L0;
      1:       return L1;
      default: return L2;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, edges);
    end
  endtask

  // Behavioural model update on each rising edge.
  always @(posedge tclk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_cnt[i] = 0;
        m_arm[i] = 1'b0;
      end else if (ct) begin
        m_cnt[i] = load_of(i);
        m_arm[i] = 1'b1;
      end else if (m_cnt[i] > 0) begin
        m_cnt[i] = m_cnt[i] - 1;
      end
    end
    edges++;
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge tclk) begin
    if (edges > 0) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("dut%0d_count", i), int'(cnt_o[i]), m_cnt[i]);
        check($sformatf("dut%0d_t", i), int'(t_o[i]),
              (m_arm[i] && m_cnt[i] == 0) ? 1 : 0);
      end
    end
  end

  task automatic step(input logic c, input logic r);
    ct    = c;
    rst_n = r;
    @(posedge tclk);
    @(negedge tclk);
  endtask

  initial begin
    rst_n = 1'b0;
    ct    = 1'b1;

    // Reset overrides ct.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("rst_count", int'(cnt_o[0]), 0);
    check("rst_t", int'(t_o[0]), 0);
    check("rst_count_2047", int'(cnt_o[2]), 0);
    $display("txn reset: count=%0d t=%0d", cnt_o[0], t_o[0]);

    // Load edge.
    step(1'b1, 1'b1);
    check("load_count", int'(cnt_o[0]), 1800);
    check("load_count_2047", int'(cnt_o[2]), 2047);
    check("load_count_1", int'(cnt_o[1]), 1);
    check("load_t", int'(t_o[0]), 0);
    $display("txn load: count=%0d/%0d/%0d", cnt_o[0], cnt_o[1], cnt_o[2]);

    // First decrement; LOAD_VAL=1 instance expires here.
    step(1'b0, 1'b1);
    check("dec1_count", int'(cnt_o[0]), 1799);
    check("lv1_t", int'(t_o[1]), 1);
    check("lv1_count", int'(cnt_o[1]), 0);
    check("dec1_count_2047", int'(cnt_o[2]), 2046);
    for (int k = 2; k <= 1800; k++) begin
      step(1'b0, 1'b1);
      if (k == 1799) begin
        check("pre_expiry_count", int'(cnt_o[0]), 1);
        check("pre_expiry_t", int'(t_o[0]), 0);
      end
    end
    check("expiry_count", int'(cnt_o[0]), 0);
    check("expiry_t", int'(t_o[0]), 1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("done_hold_t", int'(t_o[0]), 1);
    check("done_hold_count", int'(cnt_o[0]), 0);
    $display("txn basic run: expired, count=%0d t=%0d", cnt_o[0], t_o[0]);

    // Restart from DONE with ct held for two edges.
    step(1'b1, 1'b1);
    check("restart1_t", int'(t_o[0]), 0);
    check("restart1_count", int'(cnt_o[0]), 1800);
    step(1'b1, 1'b1);
    check("restart2_t", int'(t_o[0]), 0);
    check("restart2_count", int'(cnt_o[0]), 1800);
    for (int k = 1; k <= 1800; k++) begin
      step(1'b0, 1'b1);
      if (k == 1799) check("restart_pre_t", int'(t_o[0]), 0);
    end
    check("restart_expiry_t", int'(t_o[0]), 1);
    repeat (100) step(1'b0, 1'b1);
    check("restart_hold_t", int'(t_o[0]), 1);
    $display("txn restart from done: t=%0d after hold", t_o[0]);

    // Mid-count restart at count=500.
    step(1'b1, 1'b1);
    for (int k = 1; k <= 1300; k++) step(1'b0, 1'b1);
    check("mid_count_500", int'(cnt_o[0]), 500);
    step(1'b1, 1'b1);
    check("mid_restart_count", int'(cnt_o[0]), 1800);
    for (int k = 1; k <= 1800; k++) begin
      step(1'b0, 1'b1);
      if (k == 1799) check("mid_restart_pre_t", int'(t_o[0]), 0);
    end
    check("mid_restart_expiry_t", int'(t_o[0]), 1);
    $display("txn mid-count restart: t=%0d", t_o[0]);

    // Mid-count reset at count=900.
    step(1'b1, 1'b1);
    for (int k = 1; k <= 900; k++) step(1'b0, 1'b1);
    check("mid_count_900", int'(cnt_o[0]), 900);
    step(1'b0, 1'b0);
    check("mid_rst_count", int'(cnt_o[0]), 0);
    check("mid_rst_t", int'(t_o[0]), 0);
    repeat (50) step(1'b0, 1'b1);
    check("idle_hold_count", int'(cnt_o[0]), 0);
    check("idle_hold_t", int'(t_o[0]), 0);
    $display("txn mid-count reset: count=%0d t=%0d", cnt_o[0], t_o[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
